// File: rtl/apb_gpio_bridge.sv
// APB4 completer bridging pclk-domain APB accesses onto the GPIO core register port.
// The GPIO side uses a req/ack handshake so the core may insert wait states. Accesses
// outside the register window or not word-aligned get an error response without touching
// the core, and a watchdog turns a core that never acks into an error response.
//
// Ports:
//   pclk, presetn            clock (rising edge), asynchronous active-low reset
//   psel, penable, pwrite    APB control
//   paddr, pwdata, pstrb     APB address, write data, write byte strobes
//   pready, prdata, pslverr  APB response; prdata/pslverr valid while pready=1
//   gpio_req, gpio_we        GPIO access request and direction (1=write)
//   gpio_addr                window-relative byte address
//   gpio_dat_i, gpio_sel     write data and byte enables towards the core
//   gpio_ack, gpio_dat_o     access done and read data from the core
//   gpio_err                 core error, valid with gpio_ack
//   gpio_inta_o, irq         core interrupt level in, registered interrupt out
module apb_gpio_bridge #(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       GPIO_AW     = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int unsigned       TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr,
  output logic                gpio_req,
  output logic                gpio_we,
  output logic [GPIO_AW-1:0]  gpio_addr,
  output logic [DATA_W-1:0]   gpio_dat_i,
  output logic [DATA_W/8-1:0] gpio_sel,
  input  logic                gpio_ack,
  input  logic [DATA_W-1:0]   gpio_dat_o,
  input  logic                gpio_err,
  input  logic                gpio_inta_o,
  output logic                irq
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned BYTE_AW = $clog2(STRB_W);
  // Keep at least one counter bit when the watchdog is disabled.
  localparam int unsigned CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [GPIO_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                irq_q;

  logic setup, addr_ok, expire, busy, done;

  assign setup   = psel & ~penable;
  assign addr_ok = (paddr[ADDR_W-1:GPIO_AW] == BASE_ADDR[ADDR_W-1:GPIO_AW]) &&
                   (paddr[BYTE_AW-1:0] == '0);
  // cnt_q counts completed BUSY cycles, so this is the last allowed BUSY cycle.
  assign expire  = (TIMEOUT_CYC != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT_CYC);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      StIdle: begin
        if (setup) begin
          we_d    = pwrite;
          addr_d  = paddr[GPIO_AW-1:0];
          wdata_d = pwdata;
          strb_d  = pstrb;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = addr_ok ? StBusy : StErr;
        end
      end
      StBusy: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // An ack in the expiry cycle still completes normally.
        if (gpio_ack) begin
          if (!we_q) rdata_d = gpio_dat_o;
          err_d   = gpio_err;
          state_d = StDone;
        end else if (expire) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end
      end
      StErr: begin
        err_d   = 1'b1;
        rdata_d = '0;
        state_d = StDone;
      end
      StDone: begin
        // Completion (psel & penable) or abort (!psel) both return to idle.
        if (!psel || penable) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      irq_q   <= gpio_inta_o;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = (state_q == StDone);

  assign pready     = done;
  assign pslverr    = done & err_q;
  assign prdata     = (done && !err_q && !we_q) ? rdata_q : '0;
  assign gpio_req   = busy;
  assign gpio_we    = busy & we_q;
  assign gpio_addr  = busy ? addr_q : '0;
  assign gpio_dat_i = (busy && we_q) ? wdata_q : '0;
  assign gpio_sel   = busy ? (we_q ? strb_q : '1) : '0;
  assign irq        = irq_q;

endmodule
